// File: rtl/regfile_dbg_pkg.sv
// Shared encodings for the register-file debug port: host opcodes, FSM states
// and default datapath widths.
package regfile_dbg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

endpackage

// File: rtl/regfile_dbg_port.sv
// Host-side debug initiator for the register file: turns READ/WRITE/DUMP commands
// into RF port accesses and returns one response per register touched.
module regfile_dbg_port
    import regfile_dbg_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int NUM_REGS   = 32,
    parameter int PROTECT_X0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] rf_a1,
    input  logic [DATA_W-1:0] rf_rd1,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              rf_we3,
    output logic              dbg_active
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            r_state;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_rsp_last;

    logic w_x0_blocked;
    logic w_we;

    assign w_x0_blocked = (PROTECT_X0 != 0) && (r_addr == '0);
    assign w_we         = (r_state == ST_ACCESS) && (r_op == OP_WRITE) && !w_x0_blocked;

    // Reset masks the strobe combinationally so an op caught mid-ACCESS never commits.
    assign rf_we3     = w_we && !rst;
    assign rf_a1      = r_addr;
    assign rf_a3      = r_addr;
    assign rf_wd3     = r_wdata;
    assign cmd_ready  = (r_state == ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign dbg_active = (r_state != ST_IDLE);
    assign rsp_addr   = r_rsp_addr;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign rsp_last   = r_rsp_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rsp_addr <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_last <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= op_e'(cmd_op);
                        r_addr  <= (op_e'(cmd_op) == OP_DUMP) ? '0 : cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rsp_addr <= r_addr;
                    r_rsp_err  <= 1'b0;
                    r_rsp_last <= !((r_op == OP_DUMP) && (r_addr < LAST_IDX));
                    case (r_op)
                        OP_READ, OP_DUMP: r_rsp_data <= rf_rd1;
                        OP_WRITE: begin
                            if (w_x0_blocked) begin
                                r_rsp_data <= '0;
                                r_rsp_err  <= 1'b1;
                            end else begin
                                r_rsp_data <= r_wdata;
                            end
                        end
                        default: begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end
                    endcase
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    // Only a DUMP short of the last index clears rsp_last, so it doubles as "continue".
                    if (rsp_ready) begin
                        if (!r_rsp_last) begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= ST_ACCESS;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Directed bench for regfile_dbg_port paired with a simple 32x32 register file model.
module tb_regfile_dbg_port;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;
    logic [4:0]  rf_a1;
    logic [31:0] rf_rd1;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        rf_we3;
    logic        dbg_active;

    logic [31:0] rf [0:31];
    logic        rf_init;
    int          we_cnt;
    logic        wr3_seen;
    int          n_chk;
    int          n_fail;

    regfile_dbg_port #(
        .DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .PROTECT_X0(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
        .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
        .rf_we3(rf_we3), .dbg_active(dbg_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_rd1 = rf[rf_a1];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
            rf[5]    <= 32'h40;
            rf[6]    <= 32'h30;
            rf[9]    <= 32'h40;
            we_cnt   <= 0;
            wr3_seen <= 1'b0;
        end else if (rf_we3) begin
            rf[rf_a3] <= rf_wd3;
            we_cnt    <= we_cnt + 1;
            if (rf_a3 == 5'd3) wr3_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input int idx);
        case (idx)
            5:       return 32'h40;
            6:       return 32'h30;
            7:       return 32'hDEADBEEF;
            9:       return 32'h40;
            default: return 32'h0;
        endcase
    endfunction

    // Issue one command from IDLE; returns with the DUT in RESP (first response cycle).
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d, input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, "_access_vld"}, rsp_valid, 1'b0);
        chk({tag, "_access_rdy"}, cmd_ready, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_lat_vld"}, rsp_valid, 1'b1);
    endtask

    task automatic finish_rsp(input string tag);
        @(posedge clk); #1;
        chk({tag, "_idle_rdy"}, cmd_ready, 1'b1);
        chk({tag, "_idle_vld"}, rsp_valid, 1'b0);
    endtask

    initial begin
        int          w;
        int          we0;
        logic [31:0] cap_data;
        logic [4:0]  cap_addr;
        logic        cap_last;

        n_chk = 0; n_fail = 0;
        rst = 1'b1; rf_init = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rf_init = 1'b0;

        chk("rst_vld", rsp_valid, 1'b0);
        chk("rst_active", dbg_active, 1'b0);
        chk("rst_we3", rf_we3, 1'b0);
        chk("rst_data", rsp_data, 32'h0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_last", rsp_last, 1'b0);
        chk("rst_a1", rf_a1, 32'h0);

        issue(2'b00, 5'd6, 32'h0, "rd6");
        chk("rd6_data", rsp_data, 32'h30);
        chk("rd6_addr", rsp_addr, 32'd6);
        chk("rd6_last", rsp_last, 1'b1);
        chk("rd6_err", rsp_err, 1'b0);
        chk("rd6_active", dbg_active, 1'b1);
        finish_rsp("rd6");

        we0 = we_cnt;
        issue(2'b01, 5'd7, 32'hDEADBEEF, "wr7");
        chk("wr7_data", rsp_data, 32'hDEADBEEF);
        chk("wr7_err", rsp_err, 1'b0);
        chk("wr7_we3_low", rf_we3, 1'b0);
        finish_rsp("wr7");
        chk("wr7_we_pulses", we_cnt - we0, 32'd1);
        issue(2'b00, 5'd7, 32'h0, "rd7");
        chk("rd7_data", rsp_data, 32'hDEADBEEF);
        finish_rsp("rd7");

        we0 = we_cnt;
        issue(2'b01, 5'd0, 32'h1234, "wr0");
        chk("wr0_err", rsp_err, 1'b1);
        chk("wr0_data", rsp_data, 32'h0);
        chk("wr0_last", rsp_last, 1'b1);
        finish_rsp("wr0");
        chk("wr0_we_pulses", we_cnt - we0, 32'd0);
        chk("wr0_x0", rf[0], 32'h0);

        we0 = we_cnt;
        issue(2'b11, 5'd9, 32'hA5A5A5A5, "rsv");
        chk("rsv_err", rsp_err, 1'b1);
        chk("rsv_last", rsp_last, 1'b1);
        chk("rsv_data", rsp_data, 32'h0);
        finish_rsp("rsv");
        chk("rsv_we_pulses", we_cnt - we0, 32'd0);

        we0 = we_cnt;
        rsp_ready = 1'b0;
        issue(2'b10, 5'd17, 32'h0, "dump");
        for (int i = 0; i < 32; i++) begin
            w = 0;
            while (!rsp_valid && w < 8) begin
                @(posedge clk); #1;
                w++;
            end
            chk($sformatf("dump%0d_vld", i), rsp_valid, 1'b1);
            chk($sformatf("dump%0d_addr", i), rsp_addr, i[31:0]);
            chk($sformatf("dump%0d_data", i), rsp_data, exp_reg(i));
            chk($sformatf("dump%0d_last", i), rsp_last, (i == 31) ? 1'b1 : 1'b0);
            cap_data = rsp_data; cap_addr = rsp_addr; cap_last = rsp_last;
            @(posedge clk); #1;
            chk($sformatf("dump%0d_stall_vld", i), rsp_valid, 1'b1);
            chk($sformatf("dump%0d_stall_data", i), rsp_data, cap_data);
            chk($sformatf("dump%0d_stall_addr", i), rsp_addr, cap_addr);
            chk($sformatf("dump%0d_stall_last", i), rsp_last, cap_last);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        chk("dump_end_rdy", cmd_ready, 1'b1);
        chk("dump_we_pulses", we_cnt - we0, 32'd0);
        rsp_ready = 1'b1;

        cmd_op = 2'b01; cmd_addr = 5'd3; cmd_wdata = 32'h55; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rstmid_we3_pre", rf_we3, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstmid_we3_gated", rf_we3, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_rdy", cmd_ready, 1'b1);
        chk("rstmid_active", dbg_active, 1'b0);
        chk("rstmid_vld", rsp_valid, 1'b0);
        chk("rstmid_we3", rf_we3, 1'b0);
        chk("rstmid_a3", rf_a3, 32'h0);
        chk("rstmid_wd3", rf_wd3, 32'h0);
        chk("rstmid_data", rsp_data, 32'h0);
        chk("rstmid_x3", rf[3], 32'h0);
        chk("rstmid_wr3", wr3_seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
